// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry layout and default depth.
package reorder_buffer_pkg;

  localparam int ROB_LENGTH = 8;
  localparam int XLEN       = 32;
  localparam int REG_AW     = 5;

  // One in-flight instruction, from allocation until retirement.
  typedef struct packed {
    logic              valid;
    logic              ready;
    logic              mispredict;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Decode / CDB / commit bus of the reorder buffer.
// With ROB_READ_PORTS_EN defined, two operand lookup ports are added.
interface reorder_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ROB_WIDTH  = 3
);
  logic                  alloc_valid;
  logic [ADDR_WIDTH-1:0] alloc_rd_addr;
  logic                  alloc_ready;
  logic [ROB_WIDTH-1:0]  alloc_rob_entry;

  logic                  cdb_valid;
  logic [ROB_WIDTH-1:0]  cdb_rob_entry;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic                  cdb_mispredict;

  logic                  regf_we;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ROB_WIDTH-1:0]  commit_rob_entry;
  logic                  br_flush;

`ifdef ROB_READ_PORTS_EN
  logic [ROB_WIDTH-1:0]  rs1_rob_entry;
  logic [ROB_WIDTH-1:0]  rs2_rob_entry;
  logic                  rs1_ready;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic                  rs2_ready;
  logic [DATA_WIDTH-1:0] rs2_data;
`endif

  // Pipeline side: decode, functional units, register file.
  modport master (
    output alloc_valid, alloc_rd_addr, cdb_valid, cdb_rob_entry, cdb_data, cdb_mispredict,
    input  alloc_ready, alloc_rob_entry, regf_we, rd_addr, rd_data, commit_rob_entry, br_flush
`ifdef ROB_READ_PORTS_EN
    , output rs1_rob_entry, rs2_rob_entry
    , input  rs1_ready, rs1_data, rs2_ready, rs2_data
`endif
  );

  // Reorder buffer side.
  modport slave (
    input  alloc_valid, alloc_rd_addr, cdb_valid, cdb_rob_entry, cdb_data, cdb_mispredict,
    output alloc_ready, alloc_rob_entry, regf_we, rd_addr, rd_data, commit_rob_entry, br_flush
`ifdef ROB_READ_PORTS_EN
    , input  rs1_rob_entry, rs2_rob_entry
    , output rs1_ready, rs1_data, rs2_ready, rs2_data
`endif
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order CDB completion,
// in-order single retirement per cycle, full flush on a mispredicted commit.
// Optional macro ROB_READ_PORTS_EN adds two operand lookup ports.
module reorder_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_LENGTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int ROB_WIDTH  = $clog2(ROB_LENGTH)
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);
  import reorder_buffer_pkg::*;

  localparam logic [ROB_WIDTH:0]   FULL = (ROB_WIDTH+1)'(ROB_LENGTH);
  localparam logic [ROB_WIDTH-1:0] ONE  = ROB_WIDTH'(1);

  rob_entry_t           rob_q [ROB_LENGTH];
  rob_entry_t           rob_d [ROB_LENGTH];
  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  rob_entry_t head_ent;
  logic       commit, flush, do_alloc, do_wb;

  assign head_ent = rob_q[head_q];
  assign commit   = head_ent.valid & head_ent.ready;
  assign flush    = commit & head_ent.mispredict;
  // Fullness looks only at registered count; a same-cycle commit does not free a slot.
  assign do_alloc = bus.alloc_valid & bus.alloc_ready & ~flush;
  assign do_wb    = bus.cdb_valid & rob_q[bus.cdb_rob_entry].valid & ~flush;

  assign bus.alloc_ready      = (count_q != FULL);
  assign bus.alloc_rob_entry  = tail_q;
  assign bus.rd_addr          = ADDR_WIDTH'(head_ent.rd_addr);
  assign bus.rd_data          = DATA_WIDTH'(head_ent.data);
  assign bus.commit_rob_entry = head_q;
  // A flushing branch still writes its link register.
  assign bus.regf_we          = commit & (head_ent.rd_addr != '0);
  assign bus.br_flush         = flush;

`ifdef ROB_READ_PORTS_EN
  // Stored state only; operands arriving on the CDB this cycle are not bypassed.
  assign bus.rs1_ready = rob_q[bus.rs1_rob_entry].valid & rob_q[bus.rs1_rob_entry].ready;
  assign bus.rs1_data  = DATA_WIDTH'(rob_q[bus.rs1_rob_entry].data);
  assign bus.rs2_ready = rob_q[bus.rs2_rob_entry].valid & rob_q[bus.rs2_rob_entry].ready;
  assign bus.rs2_data  = DATA_WIDTH'(rob_q[bus.rs2_rob_entry].data);
`endif

  // Next state: flush wins over everything, else writeback, allocate, retire.
  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < ROB_LENGTH; i++) rob_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_wb) begin
        rob_d[bus.cdb_rob_entry].ready      = 1'b1;
        rob_d[bus.cdb_rob_entry].data       = XLEN'(bus.cdb_data);
        rob_d[bus.cdb_rob_entry].mispredict = bus.cdb_mispredict;
      end
      // Tail slot is never valid when not full, so it cannot collide with the writeback.
      if (do_alloc) begin
        rob_d[tail_q].valid      = 1'b1;
        rob_d[tail_q].ready      = 1'b0;
        rob_d[tail_q].mispredict = 1'b0;
        rob_d[tail_q].rd_addr    = REG_AW'(bus.alloc_rd_addr);
        tail_d                   = tail_q + ONE;
      end
      if (commit) begin
        rob_d[head_q].valid = 1'b0;
        head_d              = head_q + ONE;
      end
      count_d = count_q + (ROB_WIDTH+1)'(do_alloc) - (ROB_WIDTH+1)'(commit);
    end
  end

  // State registers; reset clears data too so commit outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_LENGTH; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits are queued at
// allocation and checked by a monitor whenever regf_we is seen.
module tb_reorder_buffer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RW = 3;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [RW-1:0] ent;
    logic          flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  reorder_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROB_WIDTH(RW)) bus();

  reorder_buffer #(.DATA_WIDTH(DW), .ROB_LENGTH(8), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Commit monitor: every register-file write must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.regf_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: rd=%0d data=%h ent=%0d, required no commit", bus.rd_addr, bus.rd_data, bus.commit_rob_entry);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.rd_addr, bus.rd_data, bus.commit_rob_entry, bus.br_flush} !== {e.rd, e.data, e.ent, e.flush}) begin
          errors++;
          $display("FAIL sb_commit: got rd=%0d data=%h ent=%0d flush=%b, required rd=%0d data=%h ent=%0d flush=%b",
                   bus.rd_addr, bus.rd_data, bus.commit_rob_entry, bus.br_flush, e.rd, e.data, e.ent, e.flush);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.alloc_valid    = 1'b0;
    bus.alloc_rd_addr  = '0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_rob_entry  = '0;
    bus.cdb_data       = '0;
    bus.cdb_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [AW-1:0] rd, input logic [DW-1:0] data, input logic fl, input bit push);
    exp_t e;
    e.rd = rd; e.data = data; e.ent = bus.alloc_rob_entry; e.flush = fl;
    if (push) sb.push_back(e);
    bus.alloc_valid   = 1'b1;
    bus.alloc_rd_addr = rd;
    tick();
    bus.alloc_valid   = 1'b0;
  endtask

  task automatic cdb(input logic [RW-1:0] ent, input logic [DW-1:0] data, input logic misp);
    bus.cdb_valid      = 1'b1;
    bus.cdb_rob_entry  = ent;
    bus.cdb_data       = data;
    bus.cdb_mispredict = misp;
    tick();
    bus.cdb_valid      = 1'b0;
    bus.cdb_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.alloc_ready, bus.alloc_rob_entry, bus.regf_we, bus.br_flush, bus.rd_addr, bus.rd_data, bus.commit_rob_entry}
        !== {1'b1, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b ent=%0d we=%b flush=%b rd=%0d data=%h cent=%0d, required 1 0 0 0 0 0 0",
               bus.alloc_ready, bus.alloc_rob_entry, bus.regf_we, bus.br_flush, bus.rd_addr, bus.rd_data, bus.commit_rob_entry);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    checks++;
    if (bus.alloc_rob_entry !== 3'd0) begin
      errors++; $display("FAIL basic_alloc_idx: got %0d, required 0", bus.alloc_rob_entry);
    end
    alloc(5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    checks++;
    if (bus.regf_we !== 1'b0) begin
      errors++; $display("FAIL basic_early_commit: regf_we=%b, required 0", bus.regf_we);
    end
    cdb(3'd0, 32'hDEADBEEF, 1'b0);
    checks++;
    if ({bus.regf_we, bus.rd_addr, bus.rd_data, bus.commit_rob_entry} !== {1'b1, 5'd5, 32'hDEADBEEF, 3'd0}) begin
      errors++;
      $display("FAIL basic_commit: we=%b rd=%0d data=%h ent=%0d, required 1 5 deadbeef 0",
               bus.regf_we, bus.rd_addr, bus.rd_data, bus.commit_rob_entry);
    end
    tick();
    checks++;
    if (bus.regf_we !== 1'b0 || bus.commit_rob_entry !== 3'd1) begin
      errors++; $display("FAIL basic_head_adv: we=%b head=%0d, required 0 1", bus.regf_we, bus.commit_rob_entry);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) alloc(AW'(i + 1), 32'h100 + 32'(i), 1'b0, 1'b1);
    cdb(3'd2, 32'h102, 1'b0);
    cdb(3'd1, 32'h101, 1'b0);
    checks++;
    if (bus.regf_we !== 1'b0) begin
      errors++; $display("FAIL ooo_premature: regf_we=%b, required 0", bus.regf_we);
    end
    cdb(3'd0, 32'h100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.regf_we !== 1'b1 || bus.rd_addr !== AW'(i + 1)) begin
        errors++; $display("FAIL ooo_order[%0d]: we=%b rd=%0d, required 1 %0d", i, bus.regf_we, bus.rd_addr, i + 1);
      end
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.alloc_ready !== 1'b1) begin
        errors++; $display("FAIL full_early[%0d]: alloc_ready=%b, required 1", i, bus.alloc_ready);
      end
      alloc(AW'(8 + i), 32'h1000 + 32'(i), 1'b0, 1'b1);
    end
    checks++;
    if (bus.alloc_ready !== 1'b0 || bus.alloc_rob_entry !== 3'd0) begin
      errors++; $display("FAIL full_state: ready=%b tail=%0d, required 0 0", bus.alloc_ready, bus.alloc_rob_entry);
    end
    cdb(3'd0, 32'h1000, 1'b0);
    checks++;
    if (bus.alloc_ready !== 1'b0) begin
      errors++; $display("FAIL full_commit_cycle: alloc_ready=%b, required 0", bus.alloc_ready);
    end
    bus.alloc_valid   = 1'b1;
    bus.alloc_rd_addr = 5'd21;
    tick();
    bus.alloc_valid   = 1'b0;
    checks++;
    if (bus.alloc_ready !== 1'b1 || bus.alloc_rob_entry !== 3'd0) begin
      errors++; $display("FAIL full_release: ready=%b tail=%0d, required 1 0", bus.alloc_ready, bus.alloc_rob_entry);
    end
    for (int i = 1; i < 8; i++) cdb(RW'(i), 32'h1000 + 32'(i), 1'b0);
    tick();
    checks++;
    if (sb.size() != 0 || bus.alloc_ready !== 1'b1 || bus.commit_rob_entry !== 3'd0) begin
      errors++; $display("FAIL full_drain: pending=%0d ready=%b head=%0d, required 0 1 0", sb.size(), bus.alloc_ready, bus.commit_rob_entry);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(5'd1, 32'h80, 1'b1, 1'b1);
    alloc(5'd4, 32'h0, 1'b0, 1'b0);
    cdb(3'd0, 32'h80, 1'b1);
    checks++;
    if ({bus.br_flush, bus.regf_we, bus.rd_data} !== {1'b1, 1'b1, 32'h80}) begin
      errors++; $display("FAIL flush_commit: flush=%b we=%b data=%h, required 1 1 80", bus.br_flush, bus.regf_we, bus.rd_data);
    end
    // Alloc and writeback presented during the flush cycle must be dropped.
    bus.alloc_valid   = 1'b1;
    bus.alloc_rd_addr = 5'd7;
    bus.cdb_valid     = 1'b1;
    bus.cdb_rob_entry = 3'd1;
    bus.cdb_data      = 32'h44;
    tick();
    idle_inputs();
    checks++;
    if ({bus.alloc_rob_entry, bus.alloc_ready, bus.br_flush, bus.regf_we, bus.commit_rob_entry} !== {3'd0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL flush_after: tail=%0d ready=%b flush=%b we=%b head=%0d, required 0 1 0 0 0",
               bus.alloc_rob_entry, bus.alloc_ready, bus.br_flush, bus.regf_we, bus.commit_rob_entry);
    end
    cdb(3'd1, 32'h55, 1'b0);
    checks++;
    if (bus.regf_we !== 1'b0) begin
      errors++; $display("FAIL flush_entry1_gone: regf_we=%b, required 0", bus.regf_we);
    end
    alloc(5'd9, 32'h99, 1'b0, 1'b1);
    cdb(3'd0, 32'h99, 1'b0);
    checks++;
    if (bus.rd_addr !== 5'd9 || bus.regf_we !== 1'b1) begin
      errors++; $display("FAIL flush_realloc: rd=%0d we=%b, required 9 1", bus.rd_addr, bus.regf_we);
    end
    tick();
  endtask

  task automatic test_rd0_invalid();
    do_reset();
    alloc(5'd0, 32'h0, 1'b0, 1'b0);
    cdb(3'd0, 32'h77, 1'b0);
    checks++;
    if (bus.regf_we !== 1'b0 || bus.commit_rob_entry !== 3'd0 || bus.rd_data !== 32'h77) begin
      errors++; $display("FAIL rd0_commit: we=%b head=%0d data=%h, required 0 0 77", bus.regf_we, bus.commit_rob_entry, bus.rd_data);
    end
    tick();
    checks++;
    if (bus.commit_rob_entry !== 3'd1) begin
      errors++; $display("FAIL rd0_head_adv: head=%0d, required 1", bus.commit_rob_entry);
    end
    cdb(3'd1, 32'h55, 1'b1);
    checks++;
    if ({bus.rd_data, bus.regf_we, bus.br_flush, bus.commit_rob_entry, bus.alloc_rob_entry} !== {32'h0, 1'b0, 1'b0, 3'd1, 3'd1}) begin
      errors++;
      $display("FAIL invalid_wb: data=%h we=%b flush=%b head=%0d tail=%0d, required 0 0 0 1 1",
               bus.rd_data, bus.regf_we, bus.br_flush, bus.commit_rob_entry, bus.alloc_rob_entry);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc(5'd1, 32'h11, 1'b0, 1'b1);
    for (int i = 2; i <= 4; i++) alloc(AW'(i), 32'h0, 1'b0, 1'b0);
    cdb(3'd0, 32'h11, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.alloc_ready, bus.alloc_rob_entry, bus.regf_we, bus.br_flush, bus.rd_addr, bus.rd_data, bus.commit_rob_entry}
        !== {1'b1, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_async: ready=%b ent=%0d we=%b flush=%b rd=%0d data=%h cent=%0d, required 1 0 0 0 0 0 0",
               bus.alloc_ready, bus.alloc_rob_entry, bus.regf_we, bus.br_flush, bus.rd_addr, bus.rd_data, bus.commit_rob_entry);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.alloc_rob_entry !== 3'd0 || bus.regf_we !== 1'b0) begin
      errors++; $display("FAIL reset_discard: tail=%0d we=%b, required 0 0", bus.alloc_rob_entry, bus.regf_we);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_of_order();
    test_full();
    test_mispredict();
    test_rd0_invalid();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: pending=%0d, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
